// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment driver: binary value in over valid/ready, shift-add-3 BCD
// (or hex pass-through) into a display register, scanned across DIGITS common-anode digits.
module ssd_scan_ctrl #(
    parameter int DATA_W       = 13,
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] val_in,
    input  logic              val_valid,
    output logic              val_ready,
    input  logic              hex_mode,
    input  logic              blank_lz,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    // Number of decimal digits in 2**w-1, so the accumulator never loses a carry.
    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    localparam int BCD_N = dec_digits(DATA_W);
    localparam int HEX_N = (DATA_W + 3) / 4;
    localparam int NIB_A = (BCD_N > HEX_N) ? BCD_N : HEX_N;
    localparam int NIB   = (NIB_A > DIGITS) ? NIB_A : DIGITS;
    localparam int ACC_W = NIB * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic [DATA_W-1:0]       shreg;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_adj;
    logic [CNT_W-1:0]        cnt;
    logic [DIGITS*4-1:0]     disp;
    logic                    ovf;
    logic [REFRESH_BITS-1:0] presc;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS*4-1:0]     disp_sh;
    logic [6:0]              seg_next;

    // A value transfers on a clock where val_valid && val_ready; val_ready is high only
    // in IDLE and a valid seen while it is low is dropped, never queued.
    assign val_ready = (state == S_IDLE);
    assign overflow  = ovf;

    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < NIB; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            disp  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (val_valid) begin
                        if (hex_mode) begin
                            acc   <= ACC_W'(val_in);
                            state <= S_DONE;
                        end else begin
                            shreg <= val_in;
                            acc   <= '0;
                            cnt   <= CNT_W'(DATA_W);
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    acc   <= {acc_adj[ACC_W-2:0], shreg[DATA_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    // Display register only changes here, so the scan never sees a half-built value.
                    disp  <= acc[DIGITS*4-1:0];
                    ovf   <= ((acc >> (DIGITS * 4)) != '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        disp_sh = disp >> {idx, 2'b00};
        if (ovf)
            seg_next = 7'b1111110;
        else if (blank_lz && (idx != '0) && (disp_sh == '0))
            seg_next = 7'b1111111;
        else
            seg_next = seg_decode(disp_sh[3:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            anode <= '1;
            seg   <= 7'b1111111;
        end else begin
            presc <= presc + REFRESH_BITS'(1);
            if (presc == '1)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            anode <= ~(DIGITS'(1) << idx);
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed plus randomized bench for ssd_scan_ctrl; expected digits come from plain
// division/modulo on the committed value, scan position from the cycle count since reset.
module tb_ssd_scan_ctrl;
  localparam int DATA_W = 13;
  localparam int DIGITS = 4;
  localparam int RB     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] val_in;
  logic              val_valid;
  logic              val_ready;
  logic              hex_mode;
  logic              blank_lz;
  logic              overflow;
  logic [DIGITS-1:0] anode;
  logic [6:0]        seg;

  ssd_scan_ctrl #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .val_in(val_in), .val_valid(val_valid),
    .val_ready(val_ready), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .overflow(overflow), .anode(anode), .seg(seg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mdl_val = 0;
  bit mdl_hex = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  bit hex_q[$];
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  function automatic bit mdl_ovf();
    return mdl_hex ? (mdl_val > 65535) : (mdl_val > 9999);
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    int base;
    int p;
    int hi;
    base = mdl_hex ? 16 : 10;
    p = 1;
    for (int k = 0; k < i; k++) p = p * base;
    hi = mdl_val / p;
    if (mdl_ovf()) return 7'b1111110;
    if (blank_lz && i > 0 && hi == 0) return 7'b1111111;
    return seg_tab[hi % base];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) cyc++;
    else cyc = 0;
  endtask

  task automatic check_scan();
    int idx;
    if (cyc == 0) begin
      check("anode_rst", 32'(anode), 32'hF);
      check("seg_rst", 32'(seg), 32'h7F);
    end else begin
      idx = ((cyc - 1) / 4) % DIGITS;
      check("anode", 32'(anode), 32'((~(1 << idx)) & 15));
      check("seg", 32'(seg), 32'(exp_seg(idx)));
    end
  endtask

  task automatic scan(input int n);
    repeat (n) begin
      tick();
      check_scan();
    end
  endtask

  task automatic send(input int v, input bit hx, input bit hold);
    int n;
    val_in    = DATA_W'(v);
    hex_mode  = hx;
    val_valid = 1'b1;
    exp_q.push_back(DATA_W'(v));
    hex_q.push_back(hx);
    tick();
    check_scan();
    check("ready_low_after_accept", 32'(val_ready), 32'd0);
    if (hold) val_in = DATA_W'(v ^ 13'h0AAA);
    else val_valid = 1'b0;
    n = 0;
    while (val_ready !== 1'b1 && n < 40) begin
      n++;
      tick();
      check_scan();
    end
    val_valid = 1'b0;
    check("busy_clocks", 32'(n), hx ? 32'd1 : 32'(DATA_W + 1));
    mdl_val = int'(exp_q.pop_front());
    mdl_hex = hex_q.pop_front();
    check("overflow", 32'(overflow), 32'(mdl_ovf()));
  endtask

  initial begin
    rst_n = 1'b0; val_in = '0; val_valid = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) tick();
    check("ready_rst", 32'(val_ready), 32'd1);
    check("ovf_rst", 32'(overflow), 32'd0);
    check_scan();
    rst_n = 1'b1;
    scan(20);

    send(1234, 1'b0, 1'b0);
    scan(16);

    send(8191, 1'b0, 1'b0);
    scan(16);
    send(9999, 1'b0, 1'b0);
    scan(16);

    blank_lz = 1'b1;
    send(7, 1'b0, 1'b0);
    scan(16);
    blank_lz = 1'b0;
    scan(16);
    blank_lz = 1'b1;
    send(0, 1'b0, 1'b0);
    scan(16);
    blank_lz = 1'b0;

    send(13'h1ABF, 1'b1, 1'b0);
    scan(16);
    send(1234, 1'b0, 1'b1);
    scan(1);
    check("ready_after_hold", 32'(val_ready), 32'd1);
    scan(16);

    val_in = DATA_W'(9876); hex_mode = 1'b0; val_valid = 1'b1;
    tick();
    check_scan();
    val_valid = 1'b0;
    scan(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    hex_q.delete();
    mdl_val = 0;
    mdl_hex = 1'b0;
    check("ready_mid_rst", 32'(val_ready), 32'd1);
    check("ovf_mid_rst", 32'(overflow), 32'd0);
    check_scan();
    scan(16);
    send(42, 1'b0, 1'b0);
    scan(16);

    for (int it = 0; it < 12; it++) begin
      blank_lz = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)), 1'b0);
      scan(16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
